// File: rtl/uart_pkg.sv
// Shared state encodings and parity helpers for the configurable UART core.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Callers zero-extend narrower words; the extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// RX byte FIFO: pointer-addressed register storage with a combinational head.
module uart_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              rdy,
  output logic              overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_reg [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic              full;
  logic              do_pop;
  logic              do_push;

  assign full     = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign do_pop   = pop && (count_reg != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign rdy      = (count_reg != '0);
  assign head     = rdy ? mem_reg[rd_ptr_reg] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_cfg_core.sv
// UART core: tick generator, TX and RX framers sharing one 16x oversample tick,
// loopback mux ahead of the RX synchroniser, sticky error flags and an RX FIFO.
module uart_cfg_core
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 54,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_en,
  output logic              busy,
  output logic              tx,
  input  logic              rx,
  input  logic              loopback,
  output logic [DATA_W-1:0] data_out,
  output logic              rdy,
  input  logic              rdy_clr,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  input  logic              err_clr
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic             tick_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt_reg <= '0;
      tick_reg    <= 1'b0;
    end else if (div_cnt_reg == DIV_W'(CLK_DIV - 1)) begin
      div_cnt_reg <= '0;
      tick_reg    <= 1'b1;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
      tick_reg    <= 1'b0;
    end
  end

  tx_state_t         tx_state_reg;
  logic [3:0]        tx_tick_reg;
  logic [2:0]        tx_bit_reg;
  logic              tx_stop_reg;
  logic [DATA_W-1:0] tx_shift_reg;
  logic              tx_par_reg;
  logic              tx_reg;
  logic              busy_reg;

  // Each bit advances on the 16th tick after it started.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_reg <= TX_IDLE;
      tx_tick_reg  <= '0;
      tx_bit_reg   <= '0;
      tx_stop_reg  <= 1'b0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
    end else if (tx_state_reg == TX_IDLE) begin
      tx_reg      <= 1'b1;
      tx_tick_reg <= '0;
      if (wr_en) begin
        tx_shift_reg <= data_in;
        tx_par_reg   <= parity_bit(8'(data_in), PARITY);
        tx_state_reg <= TX_START;
        tx_reg       <= 1'b0;
        busy_reg     <= 1'b1;
      end
    end else if (tick_reg) begin
      tx_tick_reg <= tx_tick_reg + 4'd1;
      if (tx_tick_reg == 4'd15) begin
        case (tx_state_reg)
          TX_START: begin
            tx_state_reg <= TX_DATA;
            tx_bit_reg   <= '0;
            tx_reg       <= tx_shift_reg[0];
          end
          TX_DATA: begin
            if (tx_bit_reg == LAST_BIT) begin
              if (PARITY != PAR_NONE) begin
                tx_state_reg <= TX_PARITY;
                tx_reg       <= tx_par_reg;
              end else begin
                tx_state_reg <= TX_STOP;
                tx_stop_reg  <= 1'b0;
                tx_reg       <= 1'b1;
              end
            end else begin
              tx_bit_reg   <= tx_bit_reg + 3'd1;
              tx_shift_reg <= tx_shift_reg >> 1;
              tx_reg       <= tx_shift_reg[1];
            end
          end
          TX_PARITY: begin
            tx_state_reg <= TX_STOP;
            tx_stop_reg  <= 1'b0;
            tx_reg       <= 1'b1;
          end
          TX_STOP: begin
            if ((STOP_BITS == 1) || tx_stop_reg) begin
              tx_state_reg <= TX_IDLE;
              busy_reg     <= 1'b0;
            end else begin
              tx_stop_reg <= 1'b1;
            end
          end
          default: tx_state_reg <= TX_IDLE;
        endcase
      end
    end
  end

  assign tx   = tx_reg;
  assign busy = busy_reg;

  logic rx_meta_reg;
  logic rx_sync_reg;
  logic rx_prev_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= loopback ? tx_reg : rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  rx_state_t         rx_state_reg;
  logic [3:0]        rx_tick_reg;
  logic [2:0]        rx_bit_reg;
  logic              rx_stop_reg;
  logic [DATA_W-1:0] rx_shift_reg;
  logic              rx_par_bad_reg;
  logic              rx_frm_bad_reg;
  logic              push_reg;
  logic [DATA_W-1:0] push_data_reg;
  logic              par_set_reg;
  logic              frm_set_reg;

  // Samples land on the 8th tick of each bit; bit boundaries on the 16th.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state_reg   <= RX_IDLE;
      rx_tick_reg    <= '0;
      rx_bit_reg     <= '0;
      rx_stop_reg    <= 1'b0;
      rx_shift_reg   <= '0;
      rx_par_bad_reg <= 1'b0;
      rx_frm_bad_reg <= 1'b0;
      push_reg       <= 1'b0;
      push_data_reg  <= '0;
      par_set_reg    <= 1'b0;
      frm_set_reg    <= 1'b0;
    end else begin
      push_reg    <= 1'b0;
      par_set_reg <= 1'b0;
      frm_set_reg <= 1'b0;
      if (rx_state_reg == RX_IDLE) begin
        if (rx_prev_reg && !rx_sync_reg) begin
          rx_state_reg   <= RX_START;
          rx_tick_reg    <= '0;
          rx_bit_reg     <= '0;
          rx_stop_reg    <= 1'b0;
          rx_par_bad_reg <= 1'b0;
          rx_frm_bad_reg <= 1'b0;
        end
      end else if (tick_reg) begin
        rx_tick_reg <= rx_tick_reg + 4'd1;
        if (rx_tick_reg == 4'd7) begin
          case (rx_state_reg)
            RX_START:  if (rx_sync_reg) rx_state_reg <= RX_IDLE;
            RX_DATA:   rx_shift_reg <= {rx_sync_reg, rx_shift_reg[DATA_W-1:1]};
            RX_PARITY: rx_par_bad_reg <= (rx_sync_reg != parity_bit(8'(rx_shift_reg), PARITY));
            RX_STOP: begin
              if ((STOP_BITS == 1) || rx_stop_reg) begin
                rx_state_reg  <= RX_IDLE;
                push_reg      <= 1'b1;
                push_data_reg <= rx_shift_reg;
                par_set_reg   <= rx_par_bad_reg;
                frm_set_reg   <= rx_frm_bad_reg | !rx_sync_reg;
              end else begin
                rx_frm_bad_reg <= rx_frm_bad_reg | !rx_sync_reg;
              end
            end
            default: rx_state_reg <= RX_IDLE;
          endcase
        end else if (rx_tick_reg == 4'd15) begin
          case (rx_state_reg)
            RX_START: begin
              rx_state_reg <= RX_DATA;
              rx_bit_reg   <= '0;
            end
            RX_DATA: begin
              if (rx_bit_reg == LAST_BIT) begin
                rx_state_reg <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                rx_stop_reg  <= 1'b0;
              end else begin
                rx_bit_reg <= rx_bit_reg + 3'd1;
              end
            end
            RX_PARITY: begin
              rx_state_reg <= RX_STOP;
              rx_stop_reg  <= 1'b0;
            end
            RX_STOP: rx_stop_reg <= 1'b1;
            default: rx_state_reg <= RX_IDLE;
          endcase
        end
      end
    end
  end

  logic fifo_overflow;

  uart_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_reg),
    .push_data (push_data_reg),
    .pop       (rdy_clr),
    .head      (data_out),
    .rdy       (rdy),
    .overflow  (fifo_overflow)
  );

  logic parity_err_reg;
  logic frame_err_reg;
  logic overrun_reg;

  // A set in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      parity_err_reg <= par_set_reg   | (parity_err_reg & !err_clr);
      frame_err_reg  <= frm_set_reg   | (frame_err_reg  & !err_clr);
      overrun_reg    <= fifo_overflow | (overrun_reg    & !err_clr);
    end
  end

  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_cfg_core.sv
// Directed plus randomized bench for uart_cfg_core against a frame-level model.
module tb_uart_cfg_core;

  localparam int DW      = 8;
  localparam int CD      = 2;
  localparam int PAR     = 1;
  localparam int SB      = 1;
  localparam int DEPTH   = 4;
  localparam int BIT_CYC = 16 * CD;
  localparam int NBITS   = 1 + DW + ((PAR != 0) ? 1 : 0) + SB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          wr_en = 1'b0;
  logic          busy;
  logic          tx;
  logic          rx = 1'b1;
  logic          loopback = 1'b0;
  logic [DW-1:0] data_out;
  logic          rdy;
  logic          rdy_clr = 1'b0;
  logic          parity_err;
  logic          frame_err;
  logic          overrun;
  logic          err_clr = 1'b0;

  uart_cfg_core #(
    .DATA_W(DW), .CLK_DIV(CD), .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .wr_en(wr_en), .busy(busy),
    .tx(tx), .rx(rx), .loopback(loopback), .data_out(data_out), .rdy(rdy),
    .rdy_clr(rdy_clr), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] model_q[$];
  logic exp_par = 1'b0;
  logic exp_frm = 1'b0;
  logic exp_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Line-level picture of a frame, index 0 = start bit, built from the rules.
  function automatic logic [NBITS-1:0] frame_bits(input logic [DW-1:0] b,
                                                  input logic bad_par, input logic bad_stop);
    logic [NBITS-1:0] f;
    logic p;
    f = '0;
    for (int i = 0; i < DW; i++) f[1 + i] = b[i];
    p = ($countones(b) % 2) == 1;
    if (PAR == 2) p = ~p;
    f[1 + DW] = p ^ bad_par;
    f[NBITS-1] = ~bad_stop;
    return f;
  endfunction

  task automatic model_rx(input logic [DW-1:0] b, input logic bad_par, input logic bad_stop);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else exp_ovr = 1'b1;
    if (bad_par) exp_par = 1'b1;
    if (bad_stop) exp_frm = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_rdy"}, rdy, (model_q.size() != 0));
    if (model_q.size() != 0) check({tag, "_data"}, data_out, model_q[0]);
    check({tag, "_perr"}, parity_err, exp_par);
    check({tag, "_ferr"}, frame_err, exp_frm);
    check({tag, "_ovr"}, overrun, exp_ovr);
  endtask

  task automatic pop_check(input string tag);
    check({tag, "_rdy"}, rdy, 1);
    if (model_q.size() != 0) begin
      check({tag, "_data"}, data_out, model_q[0]);
      void'(model_q.pop_front());
    end
    rdy_clr = 1'b1;
    @(negedge clk);
    rdy_clr = 1'b0;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_par = 1'b0;
    exp_frm = 1'b0;
    exp_ovr = 1'b0;
  endtask

  // Transmit one byte, capture the tx line mid-bit and measure busy length.
  task automatic send_tx(input logic [DW-1:0] b);
    logic [NBITS-1:0] got;
    int n;
    got = '0;
    data_in = b;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check("busy_rise", busy, 1);
    n = 0;
    while (busy === 1'b1 && n < 4000) begin
      n++;
      for (int k = 0; k < NBITS; k++)
        if (n == k * BIT_CYC + BIT_CYC / 2) got[k] = tx;
      @(negedge clk);
    end
    check("frame_len_ok", (n >= NBITS * BIT_CYC - 1) && (n <= NBITS * BIT_CYC), 1);
    check("tx_frame", got, frame_bits(b, 1'b0, 1'b0));
    repeat (4) @(negedge clk);
    model_rx(b, 1'b0, 1'b0);
  endtask

  task automatic drive_rx(input logic [DW-1:0] b, input logic bad_par, input logic bad_stop);
    logic [NBITS-1:0] f;
    f = frame_bits(b, bad_par, bad_stop);
    for (int k = 0; k < NBITS; k++) begin
      rx = f[k];
      repeat (BIT_CYC) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT_CYC) @(negedge clk);
    model_rx(b, bad_par, bad_stop);
  endtask

  initial begin
    logic [DW-1:0] b;
    int n;
    int mode;
    logic bp;
    logic bs;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_rdy", rdy, 0);
    check("rst_data", data_out, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    loopback = 1'b1;
    send_tx(8'hA5);
    check_state("a5");
    pop_check("a5_pop");
    check("a5_empty", rdy, 0);

    send_tx(8'h07);
    check_state("p07");
    pop_check("p07_pop");

    loopback = 1'b0;
    drive_rx(8'h07, 1'b1, 1'b0);
    check_state("badpar");
    pop_check("badpar_pop");
    repeat (50) @(negedge clk);
    check("perr_sticky", parity_err, 1);
    clear_errors();
    check("perr_clr", parity_err, 0);

    loopback = 1'b1;
    for (int i = 1; i <= 5; i++) send_tx(DW'(i));
    check_state("ovr");
    for (int i = 0; i < DEPTH; i++) pop_check("ovr_pop");
    check("ovr_empty", rdy, 0);
    clear_errors();
    check("ovr_clr", overrun, 0);

    loopback = 1'b0;
    rx = 1'b0;
    repeat (4 * CD) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CYC) @(negedge clk);
    check_state("glitch");

    drive_rx(8'h96, 1'b0, 1'b1);
    check_state("badstop");
    pop_check("badstop_pop");
    clear_errors();
    check("ferr_clr", frame_err, 0);

    loopback = 1'b1;
    data_in = 8'h3C;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (20) @(negedge clk);
    data_in = 8'hFF;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("ign_done", n < 2000, 1);
    repeat (2 * BIT_CYC) @(negedge clk);
    check("ign_idle", busy, 0);
    model_rx(8'h3C, 1'b0, 1'b0);
    check_state("ign");
    pop_check("ign_pop");
    check_state("ign_after");

    data_in = 8'h00;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (4 * BIT_CYC) @(negedge clk);
    check("abort_mid_tx", tx, 0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    reset = 1'b1;
    model_q.delete();
    exp_par = 1'b0;
    exp_frm = 1'b0;
    exp_ovr = 1'b0;
    repeat (3 * BIT_CYC) @(negedge clk);
    check_state("abort");
    send_tx(8'h5A);
    check_state("after_abort");
    pop_check("after_abort_pop");

    for (int it = 0; it < 10; it++) begin
      b = DW'($urandom_range(0, 255));
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        loopback = 1'b1;
        send_tx(b);
      end else begin
        loopback = 1'b0;
        bp = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        bs = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        drive_rx(b, bp, bs);
      end
      check_state("rnd");
      if ($urandom_range(0, 2) != 0 && model_q.size() != 0) pop_check("rnd_pop");
      if (exp_par || exp_frm || exp_ovr) clear_errors();
    end
    while (model_q.size() != 0) pop_check("drain");
    check("drain_empty", rdy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cfg_core.md
UART_CFG_CORE -- requirements
Module: uart_cfg_core

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame (legal 5..8).
REQ-002 Parameter CLK_DIV, default 54, clk cycles per 16x oversample tick (legal >= 2).
REQ-003 Parameter PARITY, default 0, 0 none / 1 even / 2 odd.
REQ-004 Parameter STOP_BITS, default 1, legal 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4, RX FIFO entries (power of 2, >= 2).
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 data_in  in  DATA_W  byte to transmit.
REQ-009 wr_en  in  1  one-cycle TX request.
REQ-010 busy  out  1  transmitter in a frame.
REQ-011 tx  out  1  serial output, idle high.
REQ-012 rx  in  1  serial input, asynchronous.
REQ-013 loopback  in  1  1 = RX samples internal tx and ignores the rx pin.
REQ-014 data_out  out  DATA_W  RX FIFO head.
REQ-015 rdy  out  1  RX FIFO not empty.
REQ-016 rdy_clr  in  1  pops RX FIFO head.
REQ-017 parity_err, frame_err, overrun  out  1 each  sticky error flags.
REQ-018 err_clr  in  1  clears all sticky error flags.

Function
REQ-019 Tick generator SHALL pulse one cycle every CLK_DIV clks; one bit time SHALL be 16 ticks.
REQ-020 TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-021 In IDLE, wr_en=1 SHALL latch data_in and enter START; busy SHALL be 1 from the next cycle.
REQ-022 wr_en while busy=1 SHALL be ignored, with no state or data change.
REQ-023 Frame order SHALL be: one start bit 0; DATA_W bits LSB first; optional parity bit; STOP_BITS stop bits of 1.
REQ-024 Each TX bit SHALL last exactly 16 ticks; busy SHALL drop the cycle tx returns to IDLE after the last stop bit.
REQ-025 Even parity bit SHALL be the XOR of the data bits; odd parity bit SHALL be its inverse.
REQ-026 RX input SHALL pass a 2-flop synchroniser; loopback SHALL mux before the synchroniser.
REQ-027 RX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; a falling edge in IDLE SHALL enter START.
REQ-028 START SHALL resample at tick 8; if the line is 1, return to IDLE (glitch reject) with no push and no error.
REQ-029 Data, parity and stop bits SHALL each be sampled once, at tick 8 of their bit time.
REQ-030 Parity mismatch SHALL set parity_err; any stop sample equal to 0 SHALL set frame_err; the byte SHALL still be pushed.
REQ-031 After the first stop sample RX SHALL return to IDLE; with STOP_BITS=2 it SHALL check the second stop bit first.
REQ-032 rdy SHALL be 1 when the FIFO count > 0; data_out SHALL show the head combinationally from FIFO storage.
REQ-033 rdy_clr with count=0 SHALL be ignored.
REQ-034 Push into a full FIFO SHALL discard the new byte and set overrun.
REQ-035 Push and pop in the same cycle SHALL leave count unchanged, including when full; no overrun SHALL result.
REQ-036 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-037 Sticky flags SHALL hold until err_clr=1; a same-cycle set and err_clr SHALL leave the flag set.

Reset
REQ-038 While reset=0: tx=1, busy=0, rdy=0, data_out=0, all error flags=0, both FSMs IDLE, FIFO empty, tick counter 0.
REQ-039 Reset asserted mid-frame SHALL abort the frame; tx SHALL be 1 on the next cycle and no partial byte SHALL be pushed.

Structure
REQ-040 Package uart_pkg SHALL hold the TX and RX state enums and the PARITY encoding constants.
REQ-041 RX FIFO SHALL be sub-module uart_fifo (DATA_W, FIFO_DEPTH); TX, RX and tick logic stay in uart_cfg_core.

Verification
REQ-042 CLK_DIV=2, loopback=1, send 8'hA5 -> rdy rises; data_out=A5; no error flags; frame length 160 ticks.
REQ-043 PARITY=1, send 8'h07 -> tx parity bit=1; loopback gives data_out=07 and parity_err=0; driving rx with flipped parity -> parity_err=1 until err_clr.
REQ-044 Send 5 bytes 01..05 with no rdy_clr, FIFO_DEPTH=4 -> overrun=1; pops return 01,02,03,04, then rdy=0.
REQ-045 Drive rx low for 4 ticks only -> no push, no flags; rx frame with stop=0 -> byte pushed, frame_err=1.
REQ-046 wr_en for 8'h3C, then wr_en for 8'hFF while busy -> only 3C is received.
REQ-047 reset=0 mid DATA -> tx=1 next cycle, busy=0; next frame 8'h5A received intact.
